// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding doubleword load/store slave with a fixed,
// parameterised accept-to-response latency and read-before-write response data.
module dmem_responder #(
  parameter int          DATA_W     = 64,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [63:0]       i_req_addr,
  input  logic              i_req_wen,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [DATA_W-1:0] i_req_wmask,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic [1:0]        o_dbg_state
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  generate
    if (DATA_W != 64) begin : g_bad_width
      $error("dmem_responder: DATA_W must be 64");
    end
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  // Handshake: a request transfers on a posedge where i_req_valid & o_req_ready are both
  // high; a response transfers on a posedge where o_resp_valid & i_resp_ready are both high.
  // Neither side may make valid depend on the other side's ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [63:0]           w_off;
  logic [63:0]           w_idx;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_widx;
  logic                  w_accept;

  // Out-of-range is judged on the full 64-bit index so high addresses never alias.
  assign w_off    = i_req_addr - BASE;
  assign w_idx    = w_off >> 3;
  assign w_err    = (i_req_addr < BASE) | (w_idx >= 64'(DEPTH));
  assign w_widx   = w_idx[DEPTH_LOG2-1:0];
  assign w_accept = i_req_valid & o_req_ready;

  assign o_req_ready  = (r_state == S_IDLE) & ~reset;
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_dbg_state  = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (i_resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rdata <= w_err ? '0 : r_mem[w_widx];
        r_err   <= w_err;
      end
    end
  end

  // Array is not reset; accepts cannot happen during reset since o_req_ready is low then.
  always_ff @(posedge clk) begin
    if (w_accept & i_req_wen & ~w_err) begin
      r_mem[w_widx] <= (r_mem[w_widx] & ~i_req_wmask) | (i_req_wdata & i_req_wmask);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 3, 1) share one request
// bus; a reference memory model feeds an expected-response queue.
module tb_dmem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] DEPTH = 64'd4096;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [63:0] req_wdata = '0;
  logic [63:0] req_wmask = '0;
  logic        resp_ready = 1'b0;

  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [2:0]  err;
  logic [63:0] rdat [3];
  logic [1:0]  dbg  [3];

  logic        cur_req_ready;
  logic        cur_resp_valid;
  logic        cur_err;
  logic [63:0] cur_rdata;
  logic [1:0]  cur_dbg;

  int checks = 0;
  int errors = 0;

  // {check_rdata, err, rdata}
  logic [65:0] exp_q[$];
  logic [63:0] mdl [longint];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid && sel == 2'd0), .o_req_ready(rdy[0]),
    .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_resp_valid(vld[0]), .i_resp_ready(resp_ready), .o_resp_rdata(rdat[0]), .o_resp_err(err[0]),
    .o_dbg_state(dbg[0])
  );

  dmem_responder #(.LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid && sel == 2'd1), .o_req_ready(rdy[1]),
    .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_resp_valid(vld[1]), .i_resp_ready(resp_ready), .o_resp_rdata(rdat[1]), .o_resp_err(err[1]),
    .o_dbg_state(dbg[1])
  );

  dmem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid && sel == 2'd2), .o_req_ready(rdy[2]),
    .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_resp_valid(vld[2]), .i_resp_ready(resp_ready), .o_resp_rdata(rdat[2]), .o_resp_err(err[2]),
    .o_dbg_state(dbg[2])
  );

  always_comb begin
    cur_req_ready  = rdy[sel];
    cur_resp_valid = vld[sel];
    cur_err        = err[sel];
    cur_rdata      = rdat[sel];
    cur_dbg        = dbg[sel];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference memory: returns the expected response and applies the store.
  function automatic logic [65:0] model_access(input logic [63:0] addr, input logic wen,
                                               input logic [63:0] wdata, input logic [63:0] wmask);
    logic [63:0] idx;
    logic        e;
    longint      key;
    logic [65:0] r;
    idx = (addr - BASE) >> 3;
    e   = (addr < BASE) || (idx >= DEPTH);
    key = longint'(idx) + (longint'(sel) << 40);
    if (e) r = {1'b1, 1'b1, 64'd0};
    else if (mdl.exists(key)) r = {1'b1, 1'b0, mdl[key]};
    else r = {1'b0, 1'b0, 64'd0};
    if (wen && !e) begin
      if (mdl.exists(key)) mdl[key] = (mdl[key] & ~wmask) | (wdata & wmask);
      else if (wmask == ONES) mdl[key] = wdata;
    end
    return r;
  endfunction

  // Returns at the negedge following the accept edge.
  task automatic send(input logic [63:0] addr, input logic wen,
                      input logic [63:0] wdata, input logic [63:0] wmask);
    int n = 0;
    while (!cur_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(cur_req_ready), 64'd1);
    exp_q.push_back(model_access(addr, wen, wdata, wmask));
    req_addr  = addr;
    req_wen   = wen;
    req_wdata = wdata;
    req_wmask = wmask;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 64'hDEAD_0000_0000_0000;
    req_wdata = ~wdata;
  endtask

  task automatic recv(input int hold);
    int          n = 0;
    logic [65:0] e;
    logic [63:0] snap_d;
    logic        snap_e;
    while (!cur_resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resp_valid_wait", 64'(cur_resp_valid), 64'd1);
    check("scoreboard_nonempty", 64'(exp_q.size() > 0), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    snap_d = cur_rdata;
    snap_e = cur_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(cur_resp_valid), 64'd1);
      check("hold_rdata", cur_rdata, snap_d);
      check("hold_err", 64'(cur_err), 64'(snap_e));
      check("hold_req_ready", 64'(cur_req_ready), 64'd0);
    end
    if (e[65]) check("resp_rdata", cur_rdata, e[63:0]);
    check("resp_err", 64'(cur_err), 64'(e[64]));
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_hs_valid", 64'(cur_resp_valid), 64'd0);
    check("post_hs_req_ready", 64'(cur_req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b_addr [6];
    logic        b_wen  [6];
    logic [63:0] b_data [6];
    logic [65:0] e;
    int          k, got, cyc, last;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(cur_req_ready), 64'd0);
    check("rst_resp_valid", 64'(cur_resp_valid), 64'd0);
    check("rst_rdata", cur_rdata, 64'd0);
    check("rst_err", 64'(cur_err), 64'd0);
    check("rst_state", 64'(cur_dbg), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 64'(cur_req_ready), 64'd1);

    // Store then load (LATENCY 2)
    send(BASE + 64'h8, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, ONES); recv(0);
    send(BASE + 64'h8, 1'b1, 64'h1122_3344_5566_7788, ONES); recv(0);
    send(BASE + 64'h8, 1'b0, 64'h0, 64'h0); recv(2);

    // Byte-lane mask
    send(BASE + 64'h8, 1'b1, 64'hAA << 16, 64'h0000_0000_00FF_0000); recv(0);
    send(BASE + 64'h8, 1'b0, 64'h0, 64'h0); recv(0);
    send(BASE + 64'hF, 1'b0, 64'h0, 64'h0); recv(0);

    // Range boundaries and errors
    send(BASE + 64'h7FF8, 1'b1, 64'h0123_4567_89AB_CDEF, ONES); recv(0);
    send(64'h7FFF_FFF8, 1'b0, 64'h0, 64'h0); recv(1);
    send(BASE + 64'h8000, 1'b1, 64'hFFFF_0000_FFFF_0000, ONES); recv(0);
    send(64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'h5555_5555_5555_5555, ONES); recv(0);
    send(BASE + 64'h7FF8, 1'b0, 64'h0, 64'h0); recv(0);

    // Reset one cycle after a store is accepted
    send(BASE + 64'h10, 1'b1, 64'hCAFE_F00D_1234_5678, ONES);
    reset = 1'b1;
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_valid", 64'(cur_resp_valid), 64'd0);
      check("mid_rst_ready", 64'(cur_req_ready), 64'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_rst_valid", 64'(cur_resp_valid), 64'd0);
      check("after_rst_ready", 64'(cur_req_ready), 64'd1);
    end
    send(BASE + 64'h10, 1'b0, 64'h0, 64'h0); recv(0);

    // LATENCY 3 timing and backpressure
    sel = 2'd1;
    @(negedge clk);
    send(BASE + 64'h20, 1'b1, 64'h0F0E_0D0C_0B0A_0908, ONES); recv(0);
    send(BASE + 64'h20, 1'b0, 64'h0, 64'h0);
    check("l3_c1_valid", 64'(cur_resp_valid), 64'd0);
    check("l3_c1_state", 64'(cur_dbg), 64'd1);
    @(negedge clk);
    check("l3_c2_valid", 64'(cur_resp_valid), 64'd0);
    @(negedge clk);
    check("l3_c3_valid", 64'(cur_resp_valid), 64'd1);
    recv(5);

    // LATENCY 1 back-to-back
    sel = 2'd2;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      send(BASE + 64'h100 + 64'(8 * i), 1'b1, {$urandom, $urandom}, ONES);
      recv(0);
    end
    for (int i = 0; i < 4; i++) begin
      b_addr[i] = BASE + 64'h100 + 64'(8 * i);
      b_wen[i]  = 1'b0;
      b_data[i] = 64'h0;
    end
    b_addr[4] = BASE + 64'h100; b_wen[4] = 1'b1; b_data[4] = {$urandom, $urandom};
    b_addr[5] = BASE + 64'h100; b_wen[5] = 1'b0; b_data[5] = 64'h0;
    k = 0; got = 0; cyc = 0; last = -1;
    resp_ready = 1'b1;
    req_wmask  = ONES;
    while (got < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cur_resp_valid) begin
        check("b2b_scoreboard_nonempty", 64'(exp_q.size() > 0), 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (e[65]) check("b2b_rdata", cur_rdata, e[63:0]);
        check("b2b_err", 64'(cur_err), 64'(e[64]));
        got++;
      end
      if (k < 6) begin
        req_valid = 1'b1;
        req_addr  = b_addr[k];
        req_wen   = b_wen[k];
        req_wdata = b_data[k];
        if (cur_req_ready) begin
          exp_q.push_back(model_access(b_addr[k], b_wen[k], b_data[k], ONES));
          if (last >= 0) check("b2b_spacing", 64'(cyc - last), 64'd2);
          last = cyc;
          k++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("b2b_all_responses", 64'(got), 64'd6);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
